ps2_scan_rx: RTL and testbench

Front end of the PS/2 keyboard path. It synchronises and deglitches the raw `ps2_clk`/`ps2_dat` pins and deserialises 11-bit device-to-host frames, checking start, odd parity and stop bits. It folds `E0`/`F0` prefix bytes into per-key events and buffers those events in a small first-word-fall-through FIFO. The keymap decoder downstream pops one complete key event per handshake and never handles partial frames.

---
 rtl/ps2_scan_rx.sv | 158 +++++++++++++++
 tb/tb_ps2_scan_rx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 pin conditioning, 11-bit frame receiver, E0/F0 prefix merger and event FIFO.
module ps2_scan_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_AW        = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_release,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_overflow
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [7:0] FL = 8'(FILTER_LEN - 1);
    localparam logic [23:0] TO = 24'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

    logic [1:0] s1, s2, flt;
    logic [1:0][7:0] fcnt;
    logic flt_d, fall, dat;
    state_t state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic par, par_ok, byte_good;
    logic [23:0] tcnt;
    logic ext_pend, rel_pend, is_e0, is_f0, push, pop, full, wr_en;
    logic [9:0] mem [DEPTH];
    logic [9:0] head;
    logic [FIFO_AW:0] wr_ptr, rd_ptr;

    // Index 0 is the clock line, index 1 the data line.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '1;
            s2 <= '1;
            flt <= '1;
            flt_d <= 1'b1;
            fcnt <= '0;
        end else begin
            s1 <= {ps2_dat, ps2_clk};
            s2 <= s1;
            flt_d <= flt[0];
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == flt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FL) begin
                    flt[i] <= s2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 8'd1;
                end
            end
        end
    end

    assign fall = flt_d & ~flt[0];
    assign dat = flt[1];
    assign par_ok = ^{shreg, par};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            bit_cnt <= '0;
            shreg <= '0;
            par <= 1'b0;
            tcnt <= '0;
            byte_good <= 1'b0;
            err_parity <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            byte_good <= 1'b0;
            err_parity <= 1'b0;
            err_frame <= 1'b0;
            if (fall) begin
                tcnt <= '0;
                case (state)
                    IDLE: if (!dat) begin
                        state <= DATA;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        shreg <= {dat, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PAR;
                    end
                    PAR: begin
                        par <= dat;
                        state <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        byte_good <= dat & par_ok;
                        err_parity <= ~par_ok;
                        err_frame <= par_ok & ~dat;
                    end
                endcase
            end else if (state == IDLE) begin
                tcnt <= '0;
            end else if (tcnt == TO) begin
                state <= IDLE;
                tcnt <= '0;
                err_frame <= 1'b1;
            end else begin
                tcnt <= tcnt + 24'd1;
            end
        end
    end

    // shreg holds the received byte through the cycle after the stop bit.
    assign is_e0 = shreg == 8'hE0;
    assign is_f0 = shreg == 8'hF0;
    assign push = byte_good & ~is_e0 & ~is_f0;

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_pend <= 1'b0;
            rel_pend <= 1'b0;
        end else if (err_parity | err_frame) begin
            ext_pend <= 1'b0;
            rel_pend <= 1'b0;
        end else if (byte_good) begin
            ext_pend <= is_e0 | (is_f0 & ext_pend);
            rel_pend <= is_f0 | (is_e0 & rel_pend);
        end
    end

    assign ev_valid = wr_ptr != rd_ptr;
    assign full = (wr_ptr ^ rd_ptr) == {1'b1, {FIFO_AW{1'b0}}};
    assign pop = ev_valid & ev_ready;
    assign wr_en = push & (~full | pop);
    assign err_overflow = push & full & ~pop;
    assign head = mem[rd_ptr[FIFO_AW-1:0]];
    assign ev_code = ev_valid ? head[7:0] : 8'h00;
    assign ev_release = ev_valid & head[8];
    assign ev_ext = ev_valid & head[9];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= {ext_pend, rel_pend, shreg};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb_ps2_scan_rx: directed frames through ps2_scan_rx with hand-computed expected events.
module tb_ps2_scan_rx;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;
    logic ev_ready = 1'b1;
    logic ev_valid, ev_ext, ev_release, err_parity, err_frame, err_overflow;
    logic [7:0] ev_code;
    int n_chk = 0, n_err = 0;
    int n_par = 0, n_frm = 0, n_ovf = 0;
    int cyc = 0, last_fall = 0, frm_cyc = 0;
    logic [9:0] evq[$];

    ps2_scan_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(2000), .FIFO_AW(2)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
        .ev_release(ev_release), .err_parity(err_parity), .err_frame(err_frame),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (err_parity) n_par++;
            if (err_frame) begin
                n_frm++;
                frm_cyc = cyc;
            end
            if (err_overflow) n_ovf++;
            if (ev_valid && ev_ready) evq.push_back({ev_ext, ev_release, ev_code});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ev_at(input int i);
        return (i < evq.size()) ? {22'd0, evq[i]} : 32'hDEAD;
    endfunction

    task automatic clear_log();
        evq.delete();
        n_par = 0;
        n_frm = 0;
        n_ovf = 0;
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par, input bit stop,
                        input int nfalls, input int glitch_bit);
        logic [10:0] fr;
        fr = {stop, ~(^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nfalls; i++) begin
            ps2_dat = fr[i];
            wait_clk(50);
            ps2_clk = 1'b0;
            last_fall = cyc;
            wait_clk(100);
            ps2_clk = 1'b1;
            if (i == glitch_bit) begin
                wait_clk(20);
                ps2_clk = 1'b0;
                wait_clk(2);
                ps2_clk = 1'b1;
                wait_clk(28);
            end else begin
                wait_clk(50);
            end
        end
        ps2_dat = 1'b1;
        wait_clk(200);
    endtask

    task automatic send_ok(input logic [7:0] b);
        send(b, 1'b0, 1'b1, 11, -1);
    endtask

    initial begin
        wait_clk(5);
        check("rst_valid", ev_valid, 0);
        check("rst_code", ev_code, 0);
        check("rst_flags", {ev_ext, ev_release}, 0);
        check("rst_errs", {err_parity, err_frame, err_overflow}, 0);
        reset = 1'b0;
        wait_clk(20);

        clear_log();
        send(8'h1C, 1'b0, 1'b1, 11, 3);
        check("t1_nev", evq.size(), 1);
        check("t1_ev", ev_at(0), {2'b00, 8'h1C});
        check("t1_errs", n_par + n_frm + n_ovf, 0);

        clear_log();
        send_ok(8'hF0);
        send_ok(8'h1C);
        send_ok(8'hE0);
        send_ok(8'hF0);
        send_ok(8'h75);
        check("t2_nev", evq.size(), 2);
        check("t2_rel", ev_at(0), {2'b01, 8'h1C});
        check("t2_extrel", ev_at(1), {2'b11, 8'h75});

        clear_log();
        send_ok(8'hF0);
        send(8'h1C, 1'b1, 1'b1, 11, -1);
        send_ok(8'h1C);
        check("t3_npar", n_par, 1);
        check("t3_nfrm", n_frm, 0);
        check("t3_nev", evq.size(), 1);
        check("t3_ev", ev_at(0), {2'b00, 8'h1C});

        clear_log();
        send(8'hFF, 1'b0, 1'b1, 6, -1);
        wait_clk(2100);
        check("t4_nfrm", n_frm, 1);
        check("t4_delay", (frm_cyc - last_fall >= 2000) && (frm_cyc - last_fall <= 2020), 1);
        send_ok(8'h29);
        check("t4_nev", evq.size(), 1);
        check("t4_ev", ev_at(0), {2'b00, 8'h29});

        clear_log();
        send(8'h5A, 1'b0, 1'b0, 11, -1);
        check("t5_nfrm", n_frm, 1);
        check("t5_npar", n_par, 0);
        check("t5_nev", evq.size(), 0);

        clear_log();
        ev_ready = 1'b0;
        send_ok(8'h16);
        send_ok(8'h1E);
        send_ok(8'h26);
        send_ok(8'h25);
        check("t6_novf_pre", n_ovf, 0);
        send_ok(8'h2E);
        check("t6_novf", n_ovf, 1);
        check("t6_full_valid", ev_valid, 1);
        ev_ready = 1'b1;
        wait_clk(10);
        check("t6_nev", evq.size(), 4);
        check("t6_ev0", ev_at(0), {2'b00, 8'h16});
        check("t6_ev1", ev_at(1), {2'b00, 8'h1E});
        check("t6_ev2", ev_at(2), {2'b00, 8'h26});
        check("t6_ev3", ev_at(3), {2'b00, 8'h25});
        check("t6_empty", ev_valid, 0);

        clear_log();
        ev_ready = 1'b0;
        send_ok(8'h16);
        check("t7_pre_valid", ev_valid, 1);
        send(8'h33, 1'b0, 1'b1, 4, -1);
        reset = 1'b1;
        wait_clk(2);
        check("t7_valid", ev_valid, 0);
        check("t7_code", ev_code, 0);
        check("t7_flags", {ev_ext, ev_release}, 0);
        check("t7_errs", {err_parity, err_frame, err_overflow}, 0);
        reset = 1'b0;
        ev_ready = 1'b1;
        wait_clk(2200);
        check("t7_no_timeout", n_frm, 0);
        send_ok(8'h1C);
        check("t7_resync", ev_at(0), {2'b00, 8'h1C});

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
